// File: rtl/memory_responder_if.sv
// Bus bundle between the CPU memory controller (master) and memory_responder (slave).
// WrProtHit exists only when MEM_WRITE_PROTECT_EN is defined.
interface memory_responder_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16
);
   logic                  RD;
   logic                  WR;
   logic [ADDR_WIDTH-1:0] Address;
   logic [DATA_WIDTH-1:0] DataIn;
   logic [DATA_WIDTH-1:0] DataOut;
   logic                  MFC;
   logic                  Busy;
   logic                  BusError;
`ifdef MEM_WRITE_PROTECT_EN
   logic                  WrProtHit;

   modport master (
      output RD, WR, Address, DataIn,
      input  DataOut, MFC, Busy, BusError, WrProtHit
   );
   modport slave (
      input  RD, WR, Address, DataIn,
      output DataOut, MFC, Busy, BusError, WrProtHit
   );
`else
   modport master (
      output RD, WR, Address, DataIn,
      input  DataOut, MFC, Busy, BusError
   );
   modport slave (
      input  RD, WR, Address, DataIn,
      output DataOut, MFC, Busy, BusError
   );
`endif
endinterface

// File: rtl/memory_responder.sv
// Word-addressed RAM responder for the RD/WR/MFC handshake with programmable wait states.
// Optional write protection of the low PROTECT_TOP words: define MEM_WRITE_PROTECT_EN.
module memory_responder #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 16,
   parameter int DEPTH_BITS  = 10,
   parameter int LATENCY     = 2,
   parameter int PROTECT_TOP = 64
) (
   input  logic                clk,
   input  logic                reset,
   memory_responder_if.slave   bus
);

   localparam int         DEPTH    = 1 << DEPTH_BITS;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      ACK     = 2'd2,
      RECOVER = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [DEPTH_BITS-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    is_wr_q, is_wr_d;
   logic                    mfc_q, mfc_d;
   logic                    busy_q, busy_d;
   logic                    bus_err_q, bus_err_d;
   logic [DATA_WIDTH-1:0]   dout_q, dout_d;
   logic                    prot_hit_q, prot_hit_d;
   logic                    mem_we;
   logic                    wr_protected;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

`ifdef MEM_WRITE_PROTECT_EN
   assign wr_protected = (int'(addr_q) < PROTECT_TOP);
`else
   localparam int unused_protect_top = PROTECT_TOP;
   assign wr_protected = 1'b0;
`endif

   // Upper address bits alias into the array and are deliberately dropped.
   if (ADDR_WIDTH > DEPTH_BITS) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.Address[ADDR_WIDTH-1:DEPTH_BITS];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      data_d     = data_q;
      is_wr_d    = is_wr_q;
      bus_err_d  = bus_err_q;
      dout_d     = dout_q;
      mfc_d      = 1'b0;
      prot_hit_d = 1'b0;
      mem_we     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.RD ^ bus.WR) begin
               addr_d  = bus.Address[DEPTH_BITS-1:0];
               data_d  = bus.DataIn;
               is_wr_d = bus.WR;
               cnt_d   = CNT_LOAD;
               state_d = BUSY;
            end else if (bus.RD && bus.WR) begin
               bus_err_d = 1'b1;
            end
         end
         BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               // Access and MFC land on the same edge so DataOut is valid with MFC.
               mfc_d   = 1'b1;
               state_d = ACK;
               if (is_wr_q) begin
                  if (wr_protected) prot_hit_d = 1'b1;
                  else              mem_we     = 1'b1;
               end else begin
                  dout_d = mem[addr_q];
               end
            end
         end
         ACK: begin
            state_d = RECOVER;
         end
         RECOVER: begin
            // Wait for the initiator to release so a held request cannot retrigger.
            if (!bus.RD && !bus.WR) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         is_wr_q    <= 1'b0;
         mfc_q      <= 1'b0;
         busy_q     <= 1'b0;
         bus_err_q  <= 1'b0;
         dout_q     <= '0;
         prot_hit_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         is_wr_q    <= is_wr_d;
         mfc_q      <= mfc_d;
         busy_q     <= busy_d;
         bus_err_q  <= bus_err_d;
         dout_q     <= dout_d;
         prot_hit_q <= prot_hit_d;
      end
   end

   // RAM contents survive reset; mem_we is already gated off by the reset state.
   always_ff @(posedge clk) begin
      if (mem_we) mem[addr_q] <= data_q;
   end

   assign bus.DataOut  = dout_q;
   assign bus.MFC      = mfc_q;
   assign bus.Busy     = busy_q;
   assign bus.BusError = bus_err_q;
`ifdef MEM_WRITE_PROTECT_EN
   assign bus.WrProtHit = prot_hit_q;
`else
   logic unused_prot_hit;
   assign unused_prot_hit = prot_hit_q;
`endif

endmodule
